// File: rtl/tt_sweep_signature_if.sv
// rtl/tt_sweep_signature_if.sv - sweep control, benchmark vector/response and result bundle
interface tt_sweep_signature_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3,
  parameter int SIG_W = 16
);
  logic                      start;
  logic                      abort;
  logic [N_IN-1:0]           x;
  logic [N_OUT-1:0]          f;
  logic                      busy;
  logic                      done;
  logic                      sig_valid;
  logic [SIG_W-1:0]          signature;
  logic [N_OUT*(N_IN+1)-1:0] ones_cnt;

  // master is the harness side: it issues commands and plays the benchmark netlist
  modport master (
    output start, abort, f,
    input  x, busy, done, sig_valid, signature, ones_cnt
  );

  modport slave (
    input  start, abort, f,
    output x, busy, done, sig_valid, signature, ones_cnt
  );
endinterface

// File: rtl/tt_sweep_signature.sv
// rtl/tt_sweep_signature.sv - exhaustive input sweep of a combinational netlist,
// compacted into a MISR signature and per-output ones-counts
module tt_sweep_signature #(
  parameter int               N_IN   = 4,
  parameter int               N_OUT  = 3,
  parameter int               SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021,
  parameter logic [SIG_W-1:0] SEED   = 16'hFFFF,
  parameter int               SETTLE = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  tt_sweep_signature_if.slave bus
);
  localparam int              CW          = N_IN + 1;
  localparam int              SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST    = {N_IN{1'b1}};

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t           state_q;
  logic [N_IN-1:0]  vec_q;
  logic [SW-1:0]    settle_q;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic [CW-1:0]    cnt_q [N_OUT];
  logic             busy_q;
  logic             done_q;
  logic             valid_q;
  logic             sample;

  assign sample = (state_q == SWEEP) && (settle_q == SETTLE_LAST);

  // Shift first, fold in the polynomial on the shifted-out MSB, then inject the response
  always_comb begin
    sig_d = {sig_q[SIG_W-2:0], 1'b0};
    if (sig_q[SIG_W-1]) begin
      sig_d = sig_d ^ POLY;
    end
    sig_d = sig_d ^ SIG_W'(bus.f);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      sig_q    <= SEED;
      for (int k = 0; k < N_OUT; k++) begin
        cnt_q[k] <= '0;
      end
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // abort wins over start and sampling; partial results are left in place
      if (bus.abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (bus.start) begin
              state_q  <= SWEEP;
              vec_q    <= '0;
              settle_q <= '0;
              sig_q    <= SEED;
              for (int k = 0; k < N_OUT; k++) begin
                cnt_q[k] <= '0;
              end
              busy_q   <= 1'b1;
              valid_q  <= 1'b0;
            end
          end
          SWEEP: begin
            settle_q <= settle_q + 1'b1;
            if (sample) begin
              sig_q <= sig_d;
              for (int k = 0; k < N_OUT; k++) begin
                cnt_q[k] <= cnt_q[k] + CW'(bus.f[k]);
              end
              if (vec_q != VEC_LAST) begin
                vec_q    <= vec_q + 1'b1;
                settle_q <= '0;
              end else begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                valid_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.x         = vec_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sig_valid = valid_q;
  assign bus.signature = sig_q;

  always_comb begin
    bus.ones_cnt = '0;
    for (int k = 0; k < N_OUT; k++) begin
      bus.ones_cnt[k*CW +: CW] = cnt_q[k];
    end
  end
endmodule

// File: tb/tb_tt_sweep_signature.sv
// tb/tb_tt_sweep_signature.sv - directed and random sweeps on a default instance
// and a SEED=0 / SETTLE=3 instance, checked against a truth-table model
module tb_tt_sweep_signature;
  logic clk;
  logic rst_n;
  logic dsel;
  int   n_checks;
  int   n_fail;

  logic [2:0] tt_a [16];
  logic [2:0] tt_b [16];

  tt_sweep_signature_if #(.N_IN(4), .N_OUT(3), .SIG_W(16)) ifa ();
  tt_sweep_signature_if #(.N_IN(4), .N_OUT(3), .SIG_W(16)) ifb ();

  tt_sweep_signature dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  tt_sweep_signature #(.SEED(16'h0000), .SETTLE(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  // The benchmark netlist is played by a truth-table lookup
  assign ifa.f = tt_a[ifa.x];
  assign ifb.f = tt_b[ifb.x];

  logic [3:0]  obs_x;
  logic        obs_busy, obs_done, obs_valid;
  logic [15:0] obs_sig;
  logic [14:0] obs_cnt;
  assign obs_x     = dsel ? ifb.x         : ifa.x;
  assign obs_busy  = dsel ? ifb.busy      : ifa.busy;
  assign obs_done  = dsel ? ifb.done      : ifa.done;
  assign obs_valid = dsel ? ifb.sig_valid : ifa.sig_valid;
  assign obs_sig   = dsel ? ifb.signature : ifa.signature;
  assign obs_cnt   = dsel ? ifb.ones_cnt  : ifa.ones_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (dsel) ifb.start = v; else ifa.start = v;
  endtask

  task automatic drive_abort(input logic v);
    if (dsel) ifb.abort = v; else ifa.abort = v;
  endtask

  // MISR as arithmetic: doubling past 2^16 means the MSB fell out
  function automatic logic [15:0] model_sig(input int nvec);
    int s;
    int fv;
    s = dsel ? 0 : 'hFFFF;
    for (int v = 0; v < nvec; v++) begin
      fv = dsel ? int'(tt_b[v]) : int'(tt_a[v]);
      s  = s * 2;
      if (s >= 65536) s = (s - 65536) ^ 'h1021;
      s = s ^ fv;
    end
    return 16'(s);
  endfunction

  function automatic logic [4:0] model_cnt(input int k, input int nvec);
    int c;
    int fv;
    c = 0;
    for (int v = 0; v < nvec; v++) begin
      fv = dsel ? int'(tt_b[v]) : int'(tt_a[v]);
      c += (fv >> k) & 1;
    end
    return 5'(c);
  endfunction

  function automatic logic [4:0] cnt_field(input int k);
    return obs_cnt[k*5 +: 5];
  endfunction

  task automatic check_results(input string tag, input int nvec);
    check({tag, "_sig"}, 32'(obs_sig), 32'(model_sig(nvec)));
    for (int k = 0; k < 3; k++) begin
      check({tag, "_cnt"}, 32'(cnt_field(k)), 32'(model_cnt(k, nvec)));
    end
  endtask

  // start is raised in the cycle before the capturing edge; lat counts cycles to done
  task automatic run_sweep(input int pulse_at, output int lat, output int busy_cyc,
                           output int done_cnt, output int hold_bad);
    int xc [16];
    int n;
    int settle;
    settle = dsel ? 3 : 1;
    for (int v = 0; v < 16; v++) xc[v] = 0;
    lat = 0; busy_cyc = 0; done_cnt = 0; hold_bad = 0;
    @(negedge clk);
    drive_start(1'b1);
    n = 0;
    while (n < 400 && (lat == 0 || n < lat + 3)) begin
      @(negedge clk);
      n++;
      drive_start(n == pulse_at);
      if (obs_busy) begin
        busy_cyc++;
        xc[obs_x]++;
      end
      if (obs_done) begin
        done_cnt++;
        if (lat == 0) lat = n;
      end
    end
    drive_start(1'b0);
    for (int v = 0; v < 16; v++) if (xc[v] != settle) hold_bad++;
  endtask

  task automatic check_reset_values(input string tag);
    for (int s = 0; s < 2; s++) begin
      dsel = s[0];
      #1;
      check({tag, "_x"},     32'(obs_x),     32'd0);
      check({tag, "_busy"},  32'(obs_busy),  32'd0);
      check({tag, "_done"},  32'(obs_done),  32'd0);
      check({tag, "_valid"}, 32'(obs_valid), 32'd0);
      check({tag, "_sig"},   32'(obs_sig),   s ? 32'h0000 : 32'hFFFF);
      check({tag, "_cnt"},   32'(obs_cnt),   32'd0);
    end
    dsel = 1'b0;
  endtask

  initial begin
    int lat, busy_cyc, done_cnt, hold_bad, n;
    n_checks = 0;
    n_fail   = 0;
    dsel     = 1'b0;
    ifa.start = 1'b0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.abort = 1'b0;
    for (int v = 0; v < 16; v++) begin
      tt_a[v] = 3'($urandom);
      tt_b[v] = 3'($urandom);
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Reset mid-sweep on both instances, checked without any clock edge
    @(negedge clk);
    ifa.start = 1'b1; ifb.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0; ifb.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    dsel = 1'b0;
    run_sweep(0, lat, busy_cyc, done_cnt, hold_bad);
    check("after_rst_lat", 32'(lat), 32'd17);
    check_results("after_rst", 16);

    // f3 = ~(x0 ^ x3), f1 = f2 = 0
    for (int v = 0; v < 16; v++) begin
      n = v;
      tt_a[v] = {~(n[0] ^ n[3]), 2'b00};
    end
    run_sweep(0, lat, busy_cyc, done_cnt, hold_bad);
    check("xnor_cnt1", 32'(cnt_field(0)), 32'd0);
    check("xnor_cnt2", 32'(cnt_field(1)), 32'd0);
    check("xnor_cnt3", 32'(cnt_field(2)), 32'd8);
    check("xnor_done", 32'(done_cnt), 32'd1);
    check("xnor_busy", 32'(busy_cyc), 32'd16);
    check("xnor_hold", 32'(hold_bad), 32'd0);
    check("xnor_valid", 32'(obs_valid), 32'd1);
    check_results("xnor", 16);

    for (int it = 0; it < 3; it++) begin
      for (int v = 0; v < 16; v++) tt_a[v] = 3'($urandom);
      run_sweep(0, lat, busy_cyc, done_cnt, hold_bad);
      check("rand_lat", 32'(lat), 32'd17);
      check("rand_done", 32'(done_cnt), 32'd1);
      check_results("rand", 16);
    end

    // abort together with start while vector 5 is presented
    for (int v = 0; v < 16; v++) tt_a[v] = 3'($urandom);
    @(negedge clk);
    drive_start(1'b1);
    n = 0;
    do begin
      @(negedge clk);
      drive_start(1'b0);
      n++;
    end while (!(obs_busy && obs_x == 4'd5) && n < 60);
    check("abort_reach_v5", 32'(obs_x), 32'd5);
    drive_abort(1'b1);
    drive_start(1'b1);
    @(negedge clk);
    drive_abort(1'b0);
    drive_start(1'b0);
    check("abort_busy", 32'(obs_busy), 32'd0);
    check("abort_valid", 32'(obs_valid), 32'd0);
    check_results("abort_partial", 5);
    done_cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (obs_done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_valid_hold", 32'(obs_valid), 32'd0);
    run_sweep(0, lat, busy_cyc, done_cnt, hold_bad);
    check("post_abort_lat", 32'(lat), 32'd17);
    check_results("post_abort", 16);

    // start pulsed mid-sweep, then two back-to-back starts from DONE
    for (int v = 0; v < 16; v++) tt_a[v] = 3'($urandom);
    run_sweep(4, lat, busy_cyc, done_cnt, hold_bad);
    check("midstart_lat", 32'(lat), 32'd17);
    check("midstart_done", 32'(done_cnt), 32'd1);
    check_results("midstart", 16);
    run_sweep(1, lat, busy_cyc, done_cnt, hold_bad);
    check("b2b_lat", 32'(lat), 32'd17);
    check("b2b_busy", 32'(busy_cyc), 32'd16);
    check_results("b2b", 16);

    // SEED=0, SETTLE=3 instance
    dsel = 1'b1;
    for (int v = 0; v < 16; v++) tt_b[v] = 3'(v);
    run_sweep(0, lat, busy_cyc, done_cnt, hold_bad);
    check("s3_lat", 32'(lat), 32'd49);
    check("s3_hold", 32'(hold_bad), 32'd0);
    check("s3_busy", 32'(busy_cyc), 32'd48);
    for (int k = 0; k < 3; k++) check("s3_cnt", 32'(cnt_field(k)), 32'd8);
    check_results("s3", 16);

    for (int v = 0; v < 16; v++) tt_b[v] = (v == 15) ? 3'b001 : 3'b000;
    run_sweep(0, lat, busy_cyc, done_cnt, hold_bad);
    check("and_sig", 32'(obs_sig), 32'h0001);
    check("and_cnt1", 32'(cnt_field(0)), 32'd1);
    check("and_done", 32'(done_cnt), 32'd1);

    for (int v = 0; v < 16; v++) tt_b[v] = 3'($urandom);
    run_sweep(0, lat, busy_cyc, done_cnt, hold_bad);
    check("s3_rand_lat", 32'(lat), 32'd49);
    check_results("s3_rand", 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tt_sweep_signature.md
# tt_sweep_signature

Sequential sweep-and-compact stage that sits directly around one of our generated combinational benchmark netlists (4 inputs x0..x3, 3 outputs f1..f3 by default). It drives every input vector in ascending order onto the benchmark inputs and samples the outputs after a settle window. It compacts the responses into a MISR signature plus per-output ones-counts, which the dataset tooling compares against the netlist's golden truth table.

## Interface
- N_IN, 4: benchmark input count; sweep length is 2^N_IN vectors.
- N_OUT, 3: benchmark output count, N_OUT ≤ SIG_W.
- SIG_W, 16: MISR width.
- POLY, 16'h1021: MISR feedback polynomial, taps XORed when the shifted-out MSB is 1.
- SEED, 16'hFFFF: MISR value loaded on start.
- SETTLE, 1: cycles each vector is held before sampling, ≥ 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- abort  in  1  synchronous cancel; returns to IDLE from any state.
- x  out  N_IN  registered vector to the benchmark inputs; bit 0 = x0.
- f  in  N_OUT  benchmark outputs, combinational from x; bit 0 = f1.
- busy  out  1  high in SWEEP.
- done  out  1  one-cycle pulse when the final sample is compacted.
- sig_valid  out  1  high from done until the next accepted start, abort or reset.
- signature  out  SIG_W  MISR result.
- ones_cnt  out  N_OUT*(N_IN+1)  field k = number of vectors with f[k]=1, range 0..2^N_IN.

## Operation
- States: IDLE, SWEEP, DONE.
- IDLE + start → SWEEP:
  - vec←0, x←0, settle←0, MISR←SEED, all counts←0, sig_valid←0.
- SWEEP runs one settle window per vector:
  - Each cycle, settle increments.
  - On the cycle where settle==SETTLE-1, sample f and compact.
  - On that same edge, if vec<2^N_IN-1: vec and x ←vec+1 and settle←0.
  - Otherwise go to DONE.
- Compaction on a sample edge, in this order:
  - s = {sig[SIG_W-2:0],0}.
  - If sig[SIG_W-1]: s ^= POLY.
  - s ^= zero-extended f.
  - sig←s.
  - ones_cnt[k] += f[k].
- DONE:
  - done=1 for exactly one cycle, on the first cycle in DONE.
  - Then stay in DONE with sig_valid=1 and results frozen.
  - x holds 2^N_IN-1.
- start in DONE behaves as start in IDLE.
- start while in SWEEP is ignored; there is no restart mid-sweep.
- abort has priority over start and over sampling on the same edge. It moves to IDLE, clears sig_valid, emits no done, and leaves signature and counts at their partial values.
- Arithmetic:
  - Counters are N_IN+1 bits and cannot overflow (max 2^N_IN).
  - vec is N_IN bits; the compare at 2^N_IN-1 ends the sweep, so vec never wraps.

## Timing
Reset values (rst_n low, asynchronous):
- State IDLE.
- x=0, busy=0, done=0, sig_valid=0.
- signature=SEED.
- ones_cnt=0.

Cycle-level behaviour:
- Start accepted on edge E0; busy is high from E0.
- Vector v is presented from edge E0+v*SETTLE. It is sampled at edge E0+(v+1)*SETTLE; f must settle within SETTLE cycles.
- done is high in the cycle after edge E0+2^N_IN*SETTLE; busy falls on that same edge.
- Total latency from start to done: 2^N_IN*SETTLE+1 cycles. With defaults that is 17.
- signature and ones_cnt are stable whenever sig_valid=1.
- Reset asserted mid-sweep: outputs go immediately to reset values; no done is emitted.

## Test plan
- Reset mid-sweep then release: all outputs at reset values. A following start completes with done exactly 17 cycles later (defaults).
- f = {x3^x0 inverted, 0, 0} (f3 = ~x0^x3, f1 = f2 = 0): ones_cnt → f1=0, f2=0, f3=8; done once; busy high 16 cycles.
- SEED=0, f[0] = &x, other bits 0: signature = 16'h0001 and ones_cnt[0] = 1.
- SETTLE=3, f = x[2:0]: every count = 8. x holds each value for exactly 3 cycles. done arrives 49 cycles after start.
- abort asserted at vector 5 together with start: goes to IDLE, done never pulses, sig_valid=0. A next start reseeds the MISR and clears counts.
- start pulsed during SWEEP and twice back-to-back in DONE: mid-sweep start is ignored. The DONE start relaunches and produces an identical signature for identical f.
